dmem_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-ported data memory / peripheral bus.
- Requester 0 is the CPU pipeline MEM stage; requester 1 is the UART/DMA loader.
- Accepts at most one access per cycle, issues it to the memory one cycle later, and returns registered read data one cycle after issue.
- Fairness is round-robin with a bounded burst. Requester 1 is blocked from the peripheral window.

---
 rtl/dmem_arbiter_pkg.sv | 32 +++
 rtl/dmem_arbiter_rr_burst_arb.sv | 78 +++++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam logic [2:0]  PERIPH_SEL_DEFAULT = 3'd4;
    localparam int unsigned CNT_W              = 4;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;

    // Requester-id encoding
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Command latched into the issue stage
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              id;
    } mem_cmd_t;

    // True when an address region field selects the peripheral window
    function automatic logic in_window(input logic [2:0] region, input logic [2:0] sel);
        return region == sel;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_burst_arb.sv
// Round-robin arbiter with a bounded burst for two requesters.
module rr_burst_arb
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);

    arb_state_e       state, state_n;
    logic             last, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             win;
    arb_state_e       own_w;

    // State, last-winner pointer and burst counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    // Winner selection, grants and next-state update
    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        win     = ~last;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        if (req0 && req1) begin
            case (state)
                ST_OWN0: win = (cnt < BMAX) ? REQ_CPU : REQ_DMA;
                ST_OWN1: win = (cnt < BMAX) ? REQ_DMA : REQ_CPU;
                default: win = ~last;
            endcase
        end else if (req1) begin
            win = REQ_DMA;
        end else begin
            win = REQ_CPU;
        end

        own_w = (win == REQ_DMA) ? ST_OWN1 : ST_OWN0;

        if (req0 || req1) begin
            // Grants are held off while reset is asserted
            gnt0   = reset && (win == REQ_CPU);
            gnt1   = reset && (win == REQ_DMA);
            last_n = win;
            if (state == own_w) begin
                if (cnt < BMAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end else begin
                cnt_n   = CNT_W'(1);
                state_n = own_w;
            end
        end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: arbitration, issue stage and read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX     = 4,
    parameter logic [2:0]  PERIPH_SEL    = PERIPH_SEL_DEFAULT,
    parameter bit          BLOCK_PERIPH1 = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        err1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    logic     acc0, acc1, acc, blk;
    mem_cmd_t cmd;
    logic     iss_rd, iss_id, iss_blk;

    rr_burst_arb #(
        .BURST_MAX (BURST_MAX)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // Select the accepted command and flag blocked peripheral accesses
    always_comb begin
        acc0      = req0 && gnt0;
        acc1      = req1 && gnt1;
        acc       = acc0 || acc1;
        cmd.addr  = addr0;
        cmd.wdata = wdata0;
        cmd.we    = we0;
        cmd.id    = REQ_CPU;
        if (acc1) begin
            cmd.addr  = addr1;
            cmd.wdata = wdata1;
            cmd.we    = we1;
            cmd.id    = REQ_DMA;
        end
        blk = acc1 && BLOCK_PERIPH1 && in_window(addr1[30:28], PERIPH_SEL);
    end

    // Issue stage: drive the memory one cycle after the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            err1      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iss_rd    <= 1'b0;
            iss_id    <= REQ_CPU;
            iss_blk   <= 1'b0;
        end else begin
            mem_rd  <= acc && !cmd.we && !blk;
            mem_wr  <= acc && cmd.we && !blk;
            err1    <= blk;
            iss_rd  <= acc && !cmd.we;
            iss_id  <= cmd.id;
            iss_blk <= blk;
            // Blocked accesses never expose their address to the memory bus
            if (acc && !blk) begin
                mem_addr  <= cmd.addr;
                mem_wdata <= cmd.wdata;
            end
        end
    end

    // Return stage: capture read data at the end of the issue cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= iss_rd && (iss_id == REQ_CPU);
            rvalid1 <= iss_rd && (iss_id == REQ_DMA);
            if (iss_rd && (iss_id == REQ_CPU)) begin
                rdata0 <= iss_blk ? '0 : mem_rdata;
            end
            if (iss_rd && (iss_id == REQ_DMA)) begin
                rdata1 <= iss_blk ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, err1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .err1      (err1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port memory (word-indexed by addr[9:2])
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          at;
    } mem_ev_t;

    typedef struct {
        logic [31:0] data;
        int          at;
    } rd_ev_t;

    mem_ev_t exp_mem[$];
    rd_ev_t  exp_rd0[$];
    rd_ev_t  exp_rd1[$];
    int      exp_err[$];
    mem_ev_t me;
    rd_ev_t  re;
    int      ee;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Push expected responses for an access the bench expects to be granted now
    task automatic push_exp(input logic id, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_ev_t m;
        rd_ev_t  r;
        if (id && (a[30:28] == 3'd4)) begin
            exp_err.push_back(cyc + 1);
            if (!w) begin
                r.data = 32'h0;
                r.at   = cyc + 2;
                exp_rd1.push_back(r);
            end
        end else begin
            m.wr = w; m.addr = a; m.wdata = d; m.at = cyc + 1;
            exp_mem.push_back(m);
            if (w) begin
                ref_mem[a[9:2]] = d;
            end else begin
                r.data = ref_mem[a[9:2]];
                r.at   = cyc + 2;
                if (id) exp_rd1.push_back(r);
                else    exp_rd0.push_back(r);
            end
        end
    endtask

    // One bus cycle: entered at posedge+1, returns at the next posedge+1
    task automatic do_cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            input logic eg0, input logic eg1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #3;
        chk("grant", 32'({gnt0, gnt1}), 32'({eg0, eg1}));
        if (eg0) push_exp(1'b0, w0, a0, d0);
        if (eg1) push_exp(1'b1, w1, a1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a strobe, error or read return
    always @(negedge clk) begin
        if (reset) begin
            if (mem_rd || mem_wr) begin
                if (exp_mem.size() == 0) begin
                    chk("stray_strobe", 32'({mem_wr, mem_rd}), 32'd0);
                end else begin
                    me = exp_mem.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(me.at));
                    chk("strobe_kind", 32'({mem_wr, mem_rd}), 32'({me.wr, ~me.wr}));
                    chk("strobe_addr", mem_addr, me.addr);
                    if (me.wr) chk("strobe_wdata", mem_wdata, me.wdata);
                end
            end
            if (err1) begin
                if (exp_err.size() == 0) begin
                    chk("stray_err1", 32'(err1), 32'd0);
                end else begin
                    ee = exp_err.pop_front();
                    chk("err1_cycle", 32'(cyc), 32'(ee));
                end
            end
            if (rvalid0) begin
                if (exp_rd0.size() == 0) begin
                    chk("stray_rvalid0", 32'(rvalid0), 32'd0);
                end else begin
                    re = exp_rd0.pop_front();
                    chk("rvalid0_cycle", 32'(cyc), 32'(re.at));
                    chk("rdata0", rdata0, re.data);
                end
            end
            if (rvalid1) begin
                if (exp_rd1.size() == 0) begin
                    chk("stray_rvalid1", 32'(rvalid1), 32'd0);
                end else begin
                    re = exp_rd1.pop_front();
                    chk("rvalid1_cycle", 32'(cyc), 32'(re.at));
                    chk("rdata1", rdata1, re.data);
                end
            end
        end
    end

    logic [11:0] seq;
    int          k0, k1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        mem[4]     = 32'hCAFE_0001;
        ref_mem[4] = 32'hCAFE_0001;

        // Reset held with both requesting: nothing may be granted or strobed
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200; wdata1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_strobe", 32'({mem_rd, mem_wr}), 32'd0);
        chk("rst_rvalid", 32'({rvalid0, rvalid1, err1}), 32'd0);
        chk("rst_rdata", rdata0 | rdata1, 32'd0);
        reset = 1'b1;

        // Contention: both hold req for 12 cycles, burst limit 4
        seq = 12'b0000_1111_0000;
        k0 = 0; k1 = 0;
        for (int i = 0; i < 12; i++) begin
            do_cycle(1'b1, 1'b0, 32'(32'h100 + 4 * k0), 32'h0,
                     1'b1, 1'b0, 32'(32'h200 + 4 * k1), 32'h0,
                     ~seq[11 - i], seq[11 - i]);
            if (seq[11 - i]) k1++;
            else             k0++;
        end
        idle();

        // Lone requester 1: ten back-to-back writes, then two read-backs
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 1'b0, 32'h0, 32'h0,
                     1'b1, 1'b1, 32'(32'h300 + 4 * i), 32'(32'h1000_0000 + i),
                     1'b0, 1'b1);
        end
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h324, 32'h0, 1'b0, 1'b1);
        idle();
        chk("readback_rdata1", rdata1, 32'h1000_0009);
        idle();

        // Single read of word 0x10
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        chk("single_rvalid0", 32'(rvalid0), 32'd1);
        chk("single_rdata0", rdata0, 32'hCAFE_0001);
        idle();

        // Peripheral window blocked for requester 1
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("periph_err1", 32'({err1, mem_wr}), 32'b10);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b0, 1'b1);
        idle();
        chk("periph_rd", {31'(rdata1), rvalid1}, 32'd1);
        idle();

        // Reset in the issue cycle of a read: it must vanish
        do_cycle(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_strobe", 32'(mem_rd), 32'd1);
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h120; addr1 = 32'h220; we0 = 1'b0; we1 = 1'b0;
        exp_mem.delete();
        exp_rd0.delete();
        exp_rd1.delete();
        exp_err.delete();
        #1;
        chk("mid_rst_strobe", 32'({mem_rd, mem_wr}), 32'd0);
        chk("mid_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_rdata0", rdata0, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, 32'(32'h120 + 4 * i - ((i == 4) ? 16 : 0)), 32'h0,
                     1'b1, 1'b0, 32'h220, 32'h0,
                     (i < 4), (i == 4));
        end
        repeat (4) idle();

        chk("drain_mem", 32'(exp_mem.size()), 32'd0);
        chk("drain_rd0", 32'(exp_rd0.size()), 32'd0);
        chk("drain_rd1", 32'(exp_rd1.size()), 32'd0);
        chk("drain_err", 32'(exp_err.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
